// File: rtl/stopwatch_core.sv
// stopwatch_core
// MM:SS BCD stopwatch that runs off the board clock. The divider's 1 Hz and
// 2 Hz pulses are used only as clock enables. A raw pause push-button is
// synchronized and debounced, and each debounced press toggles the pause
// flag. While adj is high the display fields are fast-advanced at 2 Hz,
// with no carry between the minutes and seconds fields.

module stopwatch_core #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_btn,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       paused,
    output logic       blink
);

    // The debounce counter never has to hold more than DEBOUNCE_CYCLES-1.
    localparam int            CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } mode_t;

    mode_t         mode;
    logic          btn_meta;
    logic          btn_sync;
    logic          btn_db;
    logic          btn_db_q;
    logic [CW-1:0] db_cnt;
    logic          press;
    logic          paused_nxt;
    logic          sec_wrap;
    logic [3:0]    sec_ones_nxt;
    logic [3:0]    sec_tens_nxt;
    logic [3:0]    min_ones_nxt;
    logic [3:0]    min_tens_nxt;

    // Advance a two-digit 00..59 BCD field by one and wrap 59 to 00. The
    // compare uses >= so that a corrupted digit can only fall back into range.
    function automatic logic [7:0] inc_field(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] r;
        if (ones >= 4'd9) begin
            if (tens >= 4'd5) r = 8'h00;
            else              r = {tens + 4'd1, 4'd0};
        end else begin
            r = {tens, ones + 4'd1};
        end
        return r;
    endfunction

    // Two-flop synchronizer that brings the asynchronous button into the clk domain.
    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the values from before the edge. With blocking assignments,
    // btn_sync would see the new btn_meta and one synchronizer stage would vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= pause_btn;
            btn_sync <= btn_meta;
        end
    end

    // Debounce. The synchronized level must differ from the accepted level for
    // DEBOUNCE_CYCLES consecutive cycles before it is taken as the new level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            if (btn_sync != btn_db) begin
                if (db_cnt == CNT_LAST) begin
                    btn_db <= btn_sync;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + CW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
            btn_db_q <= btn_db;
        end
    end

    // Only a debounced press (rising edge) acts. Releasing the button does nothing.
    assign press      = btn_db & ~btn_db_q;
    assign paused_nxt = paused ^ press;

    // Mode FSM, pause flag and blink phase. The mode register is the only
    // place adj is captured. A tick on this edge is therefore handled under
    // the mode chosen on the previous edge, and adj or pause changes take
    // effect one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode   <= ST_RUN;
            paused <= 1'b0;
            blink  <= 1'b0;
        end else begin
            paused <= paused_nxt;

            if (adj)             mode <= ST_ADJUST;
            else if (paused_nxt) mode <= ST_PAUSED;
            else                 mode <= ST_RUN;

            if (!adj)                                blink <= 1'b0;
            else if (mode == ST_ADJUST && tick_2hz) blink <= ~blink;
        end
    end

    assign sec_wrap = (sec_tens >= 4'd5) && (sec_ones >= 4'd9);

    // Next-count logic. RUN carries seconds into minutes. ADJUST bumps only
    // the selected field. PAUSED holds the count.
    // NOTE: every output gets its hold value before the case statement, so no
    // path leaves an output unassigned and no latch is inferred.
    always_comb begin
        sec_ones_nxt = sec_ones;
        sec_tens_nxt = sec_tens;
        min_ones_nxt = min_ones;
        min_tens_nxt = min_tens;
        case (mode)
            ST_RUN: begin
                if (tick_1hz) begin
                    {sec_tens_nxt, sec_ones_nxt} = inc_field(sec_tens, sec_ones);
                    if (sec_wrap) begin
                        {min_tens_nxt, min_ones_nxt} = inc_field(min_tens, min_ones);
                    end
                end
            end
            ST_ADJUST: begin
                if (tick_2hz) begin
                    if (sel) {sec_tens_nxt, sec_ones_nxt} = inc_field(sec_tens, sec_ones);
                    else     {min_tens_nxt, min_ones_nxt} = inc_field(min_tens, min_ones);
                end
            end
            default: begin
            end
        endcase
    end

    // Digit registers feeding the display driver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
        end else begin
            sec_ones <= sec_ones_nxt;
            sec_tens <= sec_tens_nxt;
            min_ones <= min_ones_nxt;
            min_tens <= min_tens_nxt;
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core
// Directed scenarios followed by randomized traffic. The reference model
// tracks time as integer minutes and seconds, and the button as a queue of
// delayed samples plus a run of disagreeing samples.

module tb_stopwatch_core;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz, tick_2hz, pause_btn, adj, sel;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       paused, blink;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_mm, m_ss;
    bit m_paused, m_blink, m_pend, m_db, m_adj_prev;
    bit dq[$];    // button samples still travelling through the two-stage delay
    bit runq[$];  // current run of synchronized samples that disagree with m_db

    stopwatch_core #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .pause_btn (pause_btn),
        .adj       (adj),
        .sel       (sel),
        .sec_ones  (sec_ones),
        .sec_tens  (sec_tens),
        .min_ones  (min_ones),
        .min_tens  (min_tens),
        .paused    (paused),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int dut_time();
        return int'(min_tens) * 1000 + int'(min_ones) * 100 + int'(sec_tens) * 10 + int'(sec_ones);
    endfunction

    function automatic int model_time();
        return m_mm * 100 + m_ss;
    endfunction

    task automatic model_reset();
        m_mm = 0; m_ss = 0;
        m_paused = 0; m_blink = 0; m_pend = 0; m_db = 0; m_adj_prev = 0;
        dq.delete(); dq.push_back(1'b0); dq.push_back(1'b0);
        runq.delete();
    endtask

    // One rising edge of the model, evaluated from the inputs as they stand now.
    task automatic model_update();
        bit syn, rose, blink_n;
        int t;
        syn = dq.pop_front();
        dq.push_back(pause_btn);
        rose = 1'b0;
        if (syn == m_db) begin
            runq.delete();
        end else begin
            runq.push_back(syn);
            if (runq.size() == DB) begin
                m_db = !m_db;
                rose = m_db;
                runq.delete();
            end
        end
        blink_n = m_blink;
        if (m_adj_prev) begin
            if (tick_2hz) begin
                if (sel) m_ss = (m_ss + 1) % 60;
                else     m_mm = (m_mm + 1) % 60;
                blink_n = !m_blink;
            end
        end else if (!m_paused && tick_1hz) begin
            t = (m_mm * 60 + m_ss + 1) % 3600;
            m_mm = t / 60;
            m_ss = t % 60;
        end
        m_blink    = adj ? blink_n : 1'b0;
        m_paused   = m_paused ^ m_pend;
        m_pend     = rose;
        m_adj_prev = adj;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".time"},   dut_time(), model_time());
        check({tag, ".paused"}, int'(paused), int'(m_paused));
        check({tag, ".blink"},  int'(blink),  int'(m_blink));
        check({tag, ".bcd"},
              int'(sec_ones <= 4'd9 && sec_tens <= 4'd5 && min_ones <= 4'd9 && min_tens <= 4'd5), 1);
    endtask

    // One clock cycle: apply the ticks, step DUT and model on the rising edge,
    // then compare on the falling edge.
    task automatic step(input bit t1, input bit t2, input string tag);
        tick_1hz = t1;
        tick_2hz = t2;
        @(posedge clk);
        model_update();
        @(negedge clk);
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        compare_all(tag);
    endtask

    // Assert reset between clock edges and expect the outputs to clear at once.
    task automatic reset_mid(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, ".rst_time"},   dut_time(), 0);
        check({tag, ".rst_paused"}, int'(paused), 0);
        check({tag, ".rst_blink"},  int'(blink), 0);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int hold;
        rst = 1'b1;
        tick_1hz = 0; tick_2hz = 0; pause_btn = 0; adj = 0; sel = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("por.time", dut_time(), 0);
        check("por.paused", int'(paused), 0);
        check("por.blink", int'(blink), 0);
        rst = 1'b0;

        // Reset behaviour: reach 00:07, reset mid-cycle, then count 3 seconds.
        for (int i = 0; i < 7; i++) begin
            step(1, 0, "cnt7");
            step(0, 0, "cnt7");
        end
        check("cnt7.final", dut_time(), 7);
        reset_mid("rst1");
        for (int i = 0; i < 3; i++) step(1, 0, "cnt3");
        check("cnt3.final", dut_time(), 3);

        // Full wrap: preload 59:58 in ADJUST, then run through 59:59 to 00:00.
        adj = 1; step(0, 0, "adj_in");
        sel = 0;
        for (int i = 0; i < 70 && m_mm != 59; i++) step(0, 1, "pre_mm");
        sel = 1;
        for (int i = 0; i < 70 && m_ss != 58; i++) step(0, 1, "pre_ss");
        check("wrap.preload", dut_time(), 5958);
        adj = 0; step(0, 0, "adj_out");
        check("wrap.blink_off", int'(blink), 0);
        step(1, 0, "wrap1");
        check("wrap.5959", dut_time(), 5959);
        step(1, 0, "wrap2");
        check("wrap.0000", dut_time(), 0);

        // Preload 12:34 for the debounce test.
        adj = 1; step(0, 0, "adj_in2");
        sel = 0;
        for (int i = 0; i < 70 && m_mm != 12; i++) step(0, 1, "pre12");
        sel = 1;
        for (int i = 0; i < 70 && m_ss != 34; i++) step(0, 1, "pre34");
        adj = 0; step(0, 0, "adj_out2");
        check("db.preload", dut_time(), 1234);

        // Bounces of 3 and 2 cycles must be rejected.
        pause_btn = 1; repeat (3) step(0, 0, "bounce_a");
        pause_btn = 0; repeat (3) step(0, 0, "bounce_b");
        pause_btn = 1; repeat (2) step(0, 0, "bounce_c");
        pause_btn = 0; repeat (8) step(0, 0, "bounce_d");
        check("db.no_toggle", int'(paused), 0);

        // Held press: paused flips exactly on edge DB+3.
        for (int i = 1; i <= 10; i++) begin
            pause_btn = 1;
            step(0, 0, "hold");
            if (i == DB + 2) check("db.edge6", int'(paused), 0);
            if (i == DB + 3) check("db.edge7", int'(paused), 1);
        end
        pause_btn = 0; repeat (8) step(0, 0, "release");
        for (int i = 0; i < 3; i++) step(1, 0, "paused_tick");
        check("db.held_1234", dut_time(), 1234);
        check("db.still_paused", int'(paused), 1);

        // Adjust without carry, starting while paused.
        adj = 1; step(0, 0, "adj_in3");
        sel = 0;
        for (int i = 0; i < 70 && m_mm != 0; i++) step(0, 1, "to00");
        sel = 1;
        for (int i = 0; i < 70 && m_ss != 58; i++) step(0, 1, "to58");
        check("adj.0058", dut_time(), 58);
        step(0, 1, "ss1"); check("adj.0059", dut_time(), 59);
        step(0, 1, "ss2"); check("adj.0000", dut_time(), 0);
        step(0, 1, "ss3"); check("adj.0001", dut_time(), 1);
        sel = 0;
        for (int i = 0; i < 70 && m_mm != 59; i++) step(0, 1, "to59");
        check("adj.5901", dut_time(), 5901);
        step(0, 1, "mm_wrap");
        check("adj.0001b", dut_time(), 1);
        adj = 0; step(0, 0, "adj_out3");
        check("adj.blink0", int'(blink), 0);

        // Pause across adjust: release the pause while in ADJUST, then exit to RUN.
        adj = 1; step(0, 0, "adj_in4");
        pause_btn = 1; repeat (DB + 4) step(0, 0, "adj_press");
        pause_btn = 0; repeat (8) step(0, 0, "adj_release");
        check("pa.unpaused", int'(paused), 0);
        adj = 0; step(0, 0, "adj_out4");
        step(1, 0, "pa.tick");
        check("pa.advanced", dut_time(), 2);

        // Simultaneous pause edge and tick at 00:09.
        for (int i = 0; i < 7; i++) step(1, 0, "to09");
        check("sim.0009", dut_time(), 9);
        for (int i = 1; i <= DB + 3; i++) begin
            pause_btn = 1;
            step(i == DB + 3, 0, "sim_hold");
        end
        check("sim.0010", dut_time(), 10);
        check("sim.paused", int'(paused), 1);
        pause_btn = 0;
        step(1, 0, "sim_ignored");
        check("sim.ignored", dut_time(), 10);

        // ADJUST with both ticks coincident: the seconds field advances once.
        adj = 1; sel = 1; step(0, 0, "adj_in5");
        step(1, 1, "both");
        check("both.0011", dut_time(), 11);
        adj = 0; step(0, 0, "adj_out5");

        // Randomized traffic with occasional mid-cycle resets.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                pause_btn = ~pause_btn;
                hold = $urandom_range(1, 12);
            end
            hold--;
            if ($urandom_range(0, 39) == 0) adj = ~adj;
            sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 399) == 0) reset_mid("rnd");
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Timekeeping stage directly downstream of the clock divider. It consumes the divider's single-cycle 1 Hz and 2 Hz enable pulses and maintains an MM:SS BCD count for the display driver. It supports pause/resume from a raw push-button, which it synchronizes and debounces, and an adjust mode that fast-advances minutes or seconds. Everything runs on the board clock; the divider's outputs are used only as clock enables, never as clocks.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive clk cycles the synchronized button must hold a new level before it is accepted (min 2).

Ports:
- clk  in  1  board clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tick_1hz  in  1  one-clk-wide enable pulse from the divider, 1 Hz.
- tick_2hz  in  1  one-clk-wide enable pulse from the divider, 2 Hz.
- pause_btn  in  1  raw, asynchronous, bouncing push-button; high = pressed.
- adj  in  1  adjust-mode switch, level; treated as quasi-static and registered once.
- sel  in  1  adjust field select; 0 = minutes, 1 = seconds.
- sec_ones  out  4  BCD, 0-9.
- sec_tens  out  4  BCD, 0-5.
- min_ones  out  4  BCD, 0-9.
- min_tens  out  4  BCD, 0-5.
- paused  out  1  pause flag.
- blink  out  1  display blink phase in adjust mode.

## Operation
- Reset (async assert, sync release effect) sets:
  - all digits = 0, paused = 0, blink = 0;
  - synchronizer and debounce state = 0;
  - mode = RUN.
- Button path:
  - 2-flop synchronizer, then debounce counter.
  - The counter increments while the synchronized level differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - A debounced rising edge toggles paused. Falling edges do nothing.
- Mode FSM, 3 states, evaluated from registered adj and paused:
  - RUN (adj=0, paused=0): each tick_1hz adds one second.
  - PAUSED (adj=0, paused=1): count holds; ticks are ignored.
  - ADJUST (adj=1, from either state): tick_1hz is ignored. Each tick_2hz increments the selected field by 1 with no carry: minutes 59→00 leaves seconds untouched, and seconds 59→00 leaves minutes untouched. blink toggles on each tick_2hz.
  - Leaving ADJUST: go to RUN or PAUSED per the current paused; blink forced to 0.
- Carry chain in RUN:
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 carries into min_ones.
  - min_ones 9→0 carries into min_tens.
  - 59:59 + 1 s → 00:00 with no overflow flag.
- Digits never leave the legal BCD ranges.
- paused toggles in every mode, including ADJUST, so the pause state is retained across adjust.

## Timing
- Count latency: digits update on the same rising edge that samples tick_1hz/tick_2hz high, i.e. visible the following cycle.
- Pause latency: paused flips exactly DEBOUNCE_CYCLES+3 clk edges after the first edge that samples pause_btn high, given the button stays high throughout.
- Bounce rejection: a pulse or bounce shorter than DEBOUNCE_CYCLES synchronized cycles produces no toggle.
- adj is registered once, so a mode change takes effect one cycle after adj changes.
- Pause edge and tick in the same cycle: the tick is applied using the pre-toggle mode; the new pause state governs from the next cycle.
- tick_1hz and tick_2hz in the same cycle:
  - ADJUST: only tick_2hz acts.
  - RUN: only tick_1hz acts.
- adj change coincident with a tick: the tick is evaluated under the old (registered) mode.
- sel is sampled on the tick_2hz edge; changing sel between ticks is legal.
- rst mid-count or mid-debounce: immediate return to reset values. No pending toggle survives.

## Test plan
Bench uses DEBOUNCE_CYCLES = 4 and drives ticks as 1-cycle pulses.
- Reset behaviour: count reaches 00:07 → assert rst between clk edges → all digits = 0, paused = 0 immediately. After release, 3 tick_1hz give 00:03.
- Full wrap: preload to 59:58 via ADJUST, return to RUN, 2 tick_1hz → 59:59, then 00:00. All intermediate digits stay in legal BCD range.
- Debounce: pause_btn high for 3 cycles, low, high for 2 cycles → paused stays 0. Then hold high for 10 cycles → paused = 1 exactly 7 edges after first high sample; ticks no longer advance 12:34.
- Adjust without carry: sel = 1 at 00:58, 3 tick_2hz → 00:59, 00:00, 00:01 (minutes stay 00). sel = 0 at 59:xx, 1 tick_2hz → 00:xx. blink toggles each tick_2hz and returns to 0 on adj = 0.
- Simultaneous events:
  - RUN at 00:09, debounced pause edge and tick_1hz in the same cycle → 00:10, paused = 1, and the next tick is ignored.
  - ADJUST with tick_1hz and tick_2hz coincident, sel = 1 → seconds +1 only once.
- Pause across adjust: pause, enter ADJUST, press pause again, exit → RUN; count advances on the next tick_1hz.
